// File: rtl/channel_stream_buffer.sv
// Per-channel frame buffer feeding pipeline_sorting_core: stores a pre-sorted frame in a
// circular FIFO, serves the core's one-word-per-read handshake and flags finish/order/overflow.
module channel_stream_buffer #(
  parameter int WIDTH      = 33,
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter bit DESCENDING = 1'b1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             wr_last,
  input  logic             close,
  output logic             full,
  output logic [AW:0]      count,
  input  logic             read,
  output logic [WIDTH-1:0] data,
  output logic             data_strobe,
  output logic             finish,
  output logic             order_error,
  output logic             overflow
);

  localparam logic [1:0] ST_OPEN   = 2'd0;
  localparam logic [1:0] ST_CLOSED = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] prev_data;
  logic             has_prev;
  logic             empty;
  logic             pop;
  logic             push;
  logic             new_frame;
  logic             out_of_order;

  // A write into a full FIFO still fits when the head is popped in the same cycle.
  assign empty        = (count == '0);
  assign full         = (count == FULL_COUNT);
  assign pop          = read && !empty;
  assign push         = wr_en && (state != ST_CLOSED) && (!full || pop);
  assign new_frame    = push && (state == ST_DONE);
  assign out_of_order = DESCENDING ? (wr_data > prev_data) : (wr_data < prev_data);

  always_comb begin
    state_next = state;
    case (state)
      ST_OPEN: begin
        if ((push && wr_last) || close) state_next = ST_CLOSED;
      end
      ST_CLOSED: begin
        if (empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (push) state_next = wr_last ? ST_CLOSED : ST_OPEN;
      end
      default: state_next = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // An empty read answers with strobe low but leaves the last delivered word on data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data        <= '0;
      data_strobe <= 1'b0;
    end else if (read) begin
      data_strobe <= pop;
      if (pop) data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state  <= ST_OPEN;
      finish <= 1'b0;
    end else begin
      state  <= state_next;
      finish <= (state == ST_DONE) && !push;
    end
  end

  // The first word after reset or after DONE has no predecessor to compare against.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prev_data   <= '0;
      has_prev    <= 1'b0;
      order_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        prev_data <= wr_data;
        has_prev  <= 1'b1;
      end
      if (new_frame) begin
        order_error <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (push && (state == ST_OPEN) && has_prev && out_of_order) order_error <= 1'b1;
        if (wr_en && !push) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_channel_stream_buffer.sv
// Scoreboard bench for channel_stream_buffer: a queue-based frame model predicts every
// output per cycle; a negedge monitor pops and compares the predictions as they fall due.
module tb_channel_stream_buffer;

  localparam int WIDTH = 33;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam bit DESC  = 1'b1;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_en = 1'b0;
  logic             wr_last = 1'b0;
  logic             close = 1'b0;
  logic             full;
  logic [AW:0]      count;
  logic             read = 1'b0;
  logic [WIDTH-1:0] data;
  logic             data_strobe;
  logic             finish;
  logic             order_error;
  logic             overflow;

  channel_stream_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .DESCENDING(DESC)
  ) dut (
    .clk(clk), .arst_n(arst_n), .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last),
    .close(close), .full(full), .count(count), .read(read), .data(data),
    .data_strobe(data_strobe), .finish(finish), .order_error(order_error),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic             strobe;
    logic [WIDTH-1:0] data;
    int               count;
    logic             full;
    logic             finish;
    logic             oerr;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  typedef enum {M_OPEN, M_CLOSED, M_DONE} mstate_t;
  logic [WIDTH-1:0] mq[$];
  mstate_t          m_state;
  logic [WIDTH-1:0] m_prev;
  logic             m_has_prev;
  logic [WIDTH-1:0] m_data;
  logic             m_strobe;
  logic             m_finish;
  logic             m_oerr;
  logic             m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_state    = M_OPEN;
    m_prev     = '0;
    m_has_prev = 1'b0;
    m_data     = '0;
    m_strobe   = 1'b0;
    m_finish   = 1'b0;
    m_oerr     = 1'b0;
    m_ovf      = 1'b0;
  endfunction

  function automatic void push_expect(input int due);
    exp_t e;
    e.due    = due;
    e.strobe = m_strobe;
    e.data   = m_data;
    e.count  = mq.size();
    e.full   = (mq.size() == DEPTH);
    e.finish = m_finish;
    e.oerr   = m_oerr;
    e.ovf    = m_ovf;
    sb.push_back(e);
  endfunction

  task automatic check_output(input exp_t e);
    total++;
    if (data_strobe !== e.strobe || data !== e.data || int'(count) != e.count ||
        full !== e.full || finish !== e.finish || order_error !== e.oerr ||
        overflow !== e.ovf) begin
      bad++;
      $display("[TB] FAIL outputs cyc=%0d got strobe=%b data=%0d count=%0d full=%b fin=%b oerr=%b ovf=%b expected strobe=%b data=%0d count=%0d full=%b fin=%b oerr=%b ovf=%b",
               cyc, data_strobe, data, count, full, finish, order_error, overflow,
               e.strobe, e.data, e.count, e.full, e.finish, e.oerr, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      total++;
      bad++;
      $display("[TB] FAIL missed_check due=%0d now=%0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) check_output(sb.pop_front());
  end

  // One clock of stimulus; the model works from the frame rules on plain queues.
  task automatic apply_stimulus(input logic we, input logic [WIDTH-1:0] wd,
                                input logic wl, input logic cl, input logic rd);
    int   size_before;
    logic popped;
    logic accept;
    wr_en   = we;
    wr_data = wd;
    wr_last = wl;
    close   = cl;
    read    = rd;
    size_before = mq.size();
    popped = rd && (size_before != 0);
    accept = we && (m_state != M_CLOSED) && (size_before < DEPTH || popped);
    if (rd) begin
      m_strobe = popped;
      if (popped) m_data = mq.pop_front();
    end
    if (accept) begin
      if (m_state == M_DONE) begin
        m_oerr = 1'b0;
        m_ovf  = 1'b0;
      end else if (m_has_prev && (DESC ? (wd > m_prev) : (wd < m_prev))) begin
        m_oerr = 1'b1;
      end
      m_prev     = wd;
      m_has_prev = 1'b1;
      mq.push_back(wd);
    end else if (we) begin
      m_ovf = 1'b1;
    end
    m_finish = (m_state == M_DONE) && !accept;
    case (m_state)
      M_OPEN:   if ((accept && wl) || cl) m_state = M_CLOSED;
      M_CLOSED: if (size_before == 0) m_state = M_DONE;
      M_DONE:   if (accept) m_state = wl ? M_CLOSED : M_OPEN;
      default:  m_state = M_OPEN;
    endcase
    push_expect(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [WIDTH-1:0] v, input logic last);
    apply_stimulus(1'b1, v, last, 1'b0, 1'b0);
  endtask

  task automatic rd(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset is asserted between edges and held across one edge; outputs must read zero.
  task automatic do_reset();
    @(negedge clk);
    #1;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    close   = 1'b0;
    read    = 1'b0;
    arst_n  = 1'b0;
    model_reset();
    push_expect(cyc + 1);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] cur;

  function automatic logic [WIDTH-1:0] next_value();
    logic [WIDTH-1:0] step;
    if ($urandom_range(0, 15) == 0) begin
      cur = {1'($urandom_range(0, 1)), 32'($urandom())};
    end else begin
      step = WIDTH'($urandom_range(0, 2));
      if (cur >= step) cur = cur - step;
    end
    return cur;
  endfunction

  initial begin
    model_reset();
    cur = {1'b1, 32'hFFFF_0000};
    do_reset();
    idle(5);

    wr(40, 1'b0); wr(30, 1'b0); wr(30, 1'b0); wr(10, 1'b1);
    rd(5);
    idle(3);

    for (int i = 0; i < DEPTH; i++) wr(WIDTH'(1000 - i), 1'b0);
    wr(0, 1'b0);
    rd(DEPTH);
    for (int i = 0; i < 10; i++) wr(WIDTH'(100 - i), i == 9);
    rd(11);
    idle(3);

    wr(50, 1'b0); wr(40, 1'b0); wr(30, 1'b0);
    apply_stimulus(1'b1, 20, 1'b0, 1'b0, 1'b1);
    rd(3);
    apply_stimulus(1'b1, 10, 1'b1, 1'b0, 1'b1);
    rd(2);
    idle(3);

    wr(5, 1'b0); wr(9, 1'b1);
    rd(3);
    idle(3);
    wr(7, 1'b1);
    rd(2);
    idle(3);

    do_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(4);
    wr(3, 1'b0); wr(2, 1'b0); wr(1, 1'b0);
    do_reset();
    idle(2);

    for (int seg = 0; seg < 12; seg++) begin
      int wp = $urandom_range(20, 90);
      int rp = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset();
        end else begin
          apply_stimulus($urandom_range(0, 99) < wp, next_value(),
                         $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                         $urandom_range(0, 99) < rp);
        end
      end
    end
    idle(2);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL leftover_checks got=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
